// File: rtl/arbitro_compuerta.sv
// arbitro_compuerta -- two-lane gate arbiter sharing one PIN verifier.
//
// A lane asks for verification on solicitud. One lane is latched by a
// round-robin pick, its PIN is compared during the single concesion cycle,
// and on a match that lane's gate opens. The gate closes after the entry
// sensor rises and then falls. If arrival and entry are both high while the
// gate is open, the lane goes into BLOQUEO. While blocked, only that lane is
// served until it presents the correct PIN.
//
// Ports
//   clock                    rising-edge clock
//   reset                    synchronous reset, active low
//   solicitud[1:0]           per-lane verify request, held until granted
//   clave_0, clave_1         16-bit BCD PIN per lane
//   sensor_llegada_vehiculo  per-lane arrival sensor
//   sensor_ingreso_vehiculo  per-lane entry sensor
//   concesion[1:0]           one-hot, one-cycle grant of the verifier
//   senal_compuerta[1:0]     per-lane gate-open command (one-hot or zero)
//   senal_alarma_pin[1:0]    too many wrong PINs on that lane
//   senal_alarma_bloqueo[1:0] lane forced into BLOQUEO
//
// Optional feature: define TIMEOUT_APERTURA_EN to close an open gate after
// TIEMPO_MAX cycles when no vehicle ever started to enter.

// Per-lane attempt counter and alarm flags.
module arbitro_compuerta_carril #(
   parameter int MAX_INTENTOS = 3
) (
   input  logic clock,
   input  logic reset,
   input  logic fallo,      // wrong PIN on an ordinary (non-blocked) attempt
   input  logic acierto,    // correct PIN
   input  logic bloquear,   // arrival+entry collision while open
   output logic alarma_pin,
   output logic alarma_bloqueo
);
   localparam int CW_RAW = $clog2(MAX_INTENTOS + 1);
   localparam int CW     = (CW_RAW < 2) ? 2 : CW_RAW;
   localparam logic [CW-1:0] MAX_C = CW'(MAX_INTENTOS);

   logic [CW-1:0] intentos;

   always_ff @(posedge clock) begin
      if (!reset) begin
         intentos       <= '0;
         alarma_pin     <= 1'b0;
         alarma_bloqueo <= 1'b0;
      end else if (acierto) begin
         intentos       <= '0;
         alarma_pin     <= 1'b0;
         alarma_bloqueo <= 1'b0;
      end else begin
         // Saturate at MAX_INTENTOS; alarm rises on the attempt that reaches it.
         if (fallo && intentos < MAX_C) begin
            intentos <= intentos + CW'(1);
            if (intentos == MAX_C - CW'(1)) alarma_pin <= 1'b1;
         end
         if (bloquear) alarma_bloqueo <= 1'b1;
      end
   end
endmodule

module arbitro_compuerta #(
   parameter logic [15:0] CLAVE_CORRECTA = 16'h3257,
   parameter int          MAX_INTENTOS   = 3,
   parameter int          TIEMPO_MAX     = 200
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [1:0]  solicitud,
   input  logic [15:0] clave_0,
   input  logic [15:0] clave_1,
   input  logic [1:0]  sensor_llegada_vehiculo,
   input  logic [1:0]  sensor_ingreso_vehiculo,
   output logic [1:0]  concesion,
   output logic [1:0]  senal_compuerta,
   output logic [1:0]  senal_alarma_pin,
   output logic [1:0]  senal_alarma_bloqueo
);
   localparam int NUM_LANES = 2;

   localparam logic [1:0] REPOSO    = 2'd0;
   localparam logic [1:0] VERIFICAR = 2'd1;
   localparam logic [1:0] ABIERTO   = 2'd2;
   localparam logic [1:0] BLOQUEO   = 2'd3;

   logic [1:0]                  estado;
   logic                        carril;      // lane being served
   logic                        prio;        // lane favoured on a tie
   logic                        en_bloqueo;  // current verify came from BLOQUEO
   logic                        ing_prev;    // entry sensor of served lane, last cycle
   logic [1:0]                  vld_pipe;    // [0] accept cycle, [1] grant/compare cycle
   logic [NUM_LANES-1:0][15:0]  claves;
   logic [NUM_LANES-1:0]        uno_carril;
   logic                        sel, acepta, clave_ok, decide, choque, cierre;
   logic [NUM_LANES-1:0]        fallo, acierto, bloquear;

   assign claves     = {clave_1, clave_0};
   assign uno_carril = carril ? 2'b10 : 2'b01;

`ifdef TIMEOUT_APERTURA_EN
   localparam int TW = $clog2(TIEMPO_MAX + 1);
   logic [TW-1:0] tmr;
   logic          subio;   // entry sensor seen high during this opening
   logic          agotado;

   assign agotado = !subio && !sensor_ingreso_vehiculo[carril] &&
                    (tmr == TW'(TIEMPO_MAX - 1));

   always_ff @(posedge clock) begin
      if (!reset) begin
         tmr   <= '0;
         subio <= 1'b0;
      end else if (estado != ABIERTO) begin
         tmr   <= '0;
         subio <= 1'b0;
      end else begin
         if (tmr != '1) tmr <= tmr + TW'(1);
         subio <= subio | sensor_ingreso_vehiculo[carril];
      end
   end
`else
   logic agotado;
   assign agotado = 1'b0;
`endif

   always_comb begin
      sel      = (&solicitud) ? prio : solicitud[1];
      acepta   = ((estado == REPOSO) && (|solicitud)) ||
                 ((estado == BLOQUEO) && solicitud[carril]);
      clave_ok = (claves[carril] == CLAVE_CORRECTA);
      decide   = (estado == VERIFICAR) && vld_pipe[1];
      choque   = (estado == ABIERTO) && sensor_llegada_vehiculo[carril] &&
                 sensor_ingreso_vehiculo[carril];
      cierre   = ing_prev && !sensor_ingreso_vehiculo[carril];
      fallo    = (decide && !clave_ok && !en_bloqueo) ? uno_carril : 2'b00;
      acierto  = (decide && clave_ok) ? uno_carril : 2'b00;
      bloquear = choque ? uno_carril : 2'b00;
   end

   assign concesion       = decide ? uno_carril : 2'b00;
   assign senal_compuerta = (estado == ABIERTO) ? uno_carril : 2'b00;

   always_ff @(posedge clock) begin
      if (!reset) begin
         estado     <= REPOSO;
         carril     <= 1'b0;
         prio       <= 1'b0;
         en_bloqueo <= 1'b0;
         ing_prev   <= 1'b0;
         vld_pipe   <= '0;
      end else begin
         vld_pipe <= {vld_pipe[0], acepta};
         ing_prev <= (estado == ABIERTO) ? sensor_ingreso_vehiculo[carril] : 1'b0;
         case (estado)
            REPOSO: if (acepta) begin
               carril     <= sel;
               prio       <= ~sel;
               en_bloqueo <= 1'b0;
               estado     <= VERIFICAR;
            end
            VERIFICAR: if (decide) begin
               if (clave_ok) begin
                  en_bloqueo <= 1'b0;
                  estado     <= ABIERTO;
               end else begin
                  // a wrong PIN while blocked leaves the lane blocked
                  estado <= en_bloqueo ? BLOQUEO : REPOSO;
               end
            end
            ABIERTO: begin
               if (choque) begin
                  en_bloqueo <= 1'b1;
                  estado     <= BLOQUEO;
               end else if (cierre || agotado) begin
                  estado <= REPOSO;
               end
            end
            BLOQUEO: if (acepta) begin
               prio   <= ~carril;
               estado <= VERIFICAR;
            end
            default: estado <= REPOSO;
         endcase
      end
   end

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_carril
      arbitro_compuerta_carril #(.MAX_INTENTOS(MAX_INTENTOS)) u_carril (
         .clock         (clock),
         .reset         (reset),
         .fallo         (fallo[i]),
         .acierto       (acierto[i]),
         .bloquear      (bloquear[i]),
         .alarma_pin    (senal_alarma_pin[i]),
         .alarma_bloqueo(senal_alarma_bloqueo[i])
      );
   end
endmodule

// File: tb/tb_arbitro_compuerta.sv
module tb_arbitro_compuerta;
   logic        clock = 1'b0;
   logic        reset;
   logic [1:0]  solicitud;
   logic [15:0] clave_0, clave_1;
   logic [1:0]  sensor_llegada_vehiculo, sensor_ingreso_vehiculo;
   logic [1:0]  concesion, senal_compuerta, senal_alarma_pin, senal_alarma_bloqueo;

   int n_chk  = 0;
   int n_fail = 0;

   arbitro_compuerta dut (
      .clock                  (clock),
      .reset                  (reset),
      .solicitud              (solicitud),
      .clave_0                (clave_0),
      .clave_1                (clave_1),
      .sensor_llegada_vehiculo(sensor_llegada_vehiculo),
      .sensor_ingreso_vehiculo(sensor_ingreso_vehiculo),
      .concesion              (concesion),
      .senal_compuerta        (senal_compuerta),
      .senal_alarma_pin       (senal_alarma_pin),
      .senal_alarma_bloqueo   (senal_alarma_bloqueo)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset(input string tag);
      reset = 1'b0;
      tick();
      chk({tag, "_gate"}, {30'd0, senal_compuerta}, 32'd0);
      chk({tag, "_con"},  {30'd0, concesion}, 32'd0);
      chk({tag, "_apin"}, {30'd0, senal_alarma_pin}, 32'd0);
      chk({tag, "_ablq"}, {30'd0, senal_alarma_bloqueo}, 32'd0);
      reset = 1'b1;
   endtask

   // Raise req bits, expect no grant after the sampling edge, expect grant
   // 'exp' one edge later, drop the granted bit, and step to the decision edge.
   task automatic pedir(input logic [1:0] req, input logic [1:0] exp, input string tag);
      solicitud = solicitud | req;
      tick();
      chk({tag, "_pre"}, {30'd0, concesion}, 32'd0);
      tick();
      chk({tag, "_con"}, {30'd0, concesion}, {30'd0, exp});
      solicitud = solicitud & ~exp;
      tick();
      chk({tag, "_post"}, {30'd0, concesion}, 32'd0);
   endtask

   // Entry sensor rises then falls; gate stays up through the rise, drops after the fall.
   task automatic cerrar(input int lane, input string tag);
      logic [1:0] oh;
      oh = (lane == 0) ? 2'b01 : 2'b10;
      sensor_ingreso_vehiculo = oh;
      tick();
      chk({tag, "_hold"}, {30'd0, senal_compuerta}, {30'd0, oh});
      sensor_ingreso_vehiculo = 2'b00;
      tick();
      chk({tag, "_shut"}, {30'd0, senal_compuerta}, 32'd0);
   endtask

   initial begin
      reset = 1'b0;
      solicitud = 2'b00;
      clave_0 = 16'h0000;
      clave_1 = 16'h0000;
      sensor_llegada_vehiculo = 2'b00;
      sensor_ingreso_vehiculo = 2'b00;
      tick();
      do_reset("rst0");

      // Lane 0 correct PIN: grant, open, close on entry fall.
      clave_0 = 16'h3257;
      pedir(2'b01, 2'b01, "l0_ok");
      chk("l0_gate", {30'd0, senal_compuerta}, 32'd1);
      cerrar(0, "l0_close");

      // Lane 1 three wrong PINs raise the PIN alarm, then a good one clears it.
      clave_1 = 16'h7523;
      pedir(2'b10, 2'b10, "l1_w1");
      chk("l1_w1_gate", {30'd0, senal_compuerta}, 32'd0);
      chk("l1_w1_apin", {30'd0, senal_alarma_pin}, 32'd0);
      clave_1 = 16'h4368;
      pedir(2'b10, 2'b10, "l1_w2");
      chk("l1_w2_apin", {30'd0, senal_alarma_pin}, 32'd0);
      clave_1 = 16'h2656;
      pedir(2'b10, 2'b10, "l1_w3");
      chk("l1_w3_gate", {30'd0, senal_compuerta}, 32'd0);
      chk("l1_w3_apin", {30'd0, senal_alarma_pin}, 32'd2);
      clave_1 = 16'h3257;
      pedir(2'b10, 2'b10, "l1_ok");
      chk("l1_ok_apin", {30'd0, senal_alarma_pin}, 32'd0);
      chk("l1_ok_gate", {30'd0, senal_compuerta}, 32'd2);
      cerrar(1, "l1_close");

      // Round robin: tie after reset -> lane 0, lane 1 held then served.
      do_reset("rst1");
      clave_0 = 16'h3257;
      clave_1 = 16'h3257;
      pedir(2'b11, 2'b01, "rr_a");
      chk("rr_a_gate", {30'd0, senal_compuerta}, 32'd1);
      chk("rr_a_held", {30'd0, solicitud}, 32'd2);
      cerrar(0, "rr_a_close");
      tick();
      chk("rr_b_pre", {30'd0, concesion}, 32'd0);
      tick();
      chk("rr_b_con", {30'd0, concesion}, 32'd2);
      solicitud = 2'b00;
      tick();
      chk("rr_b_gate", {30'd0, senal_compuerta}, 32'd2);
      cerrar(1, "rr_b_close");
      clave_0 = 16'h1111;
      pedir(2'b01, 2'b01, "rr_c");
      chk("rr_c_gate", {30'd0, senal_compuerta}, 32'd0);
      // last grant was lane 0, so the next tie goes to lane 1
      pedir(2'b11, 2'b10, "rr_d");
      chk("rr_d_gate", {30'd0, senal_compuerta}, 32'd2);
      solicitud = 2'b00;

      // Collision while open -> BLOQUEO; wrong PIN keeps it; right PIN reopens.
      do_reset("rst2");
      clave_0 = 16'h3257;
      pedir(2'b01, 2'b01, "bq_open");
      chk("bq_open_gate", {30'd0, senal_compuerta}, 32'd1);
      sensor_llegada_vehiculo = 2'b01;
      sensor_ingreso_vehiculo = 2'b01;
      tick();
      sensor_llegada_vehiculo = 2'b00;
      sensor_ingreso_vehiculo = 2'b00;
      chk("bq_ablq", {30'd0, senal_alarma_bloqueo}, 32'd1);
      chk("bq_gate", {30'd0, senal_compuerta}, 32'd0);
      solicitud = 2'b10;               // lane 1 must be held off while blocked
      clave_0 = 16'h5479;
      pedir(2'b01, 2'b01, "bq_wrong");
      chk("bq_wrong_ablq", {30'd0, senal_alarma_bloqueo}, 32'd1);
      chk("bq_wrong_gate", {30'd0, senal_compuerta}, 32'd0);
      chk("bq_wrong_apin", {30'd0, senal_alarma_pin}, 32'd0);
      clave_0 = 16'h3257;
      pedir(2'b01, 2'b01, "bq_ok");
      chk("bq_ok_ablq", {30'd0, senal_alarma_bloqueo}, 32'd0);
      chk("bq_ok_gate", {30'd0, senal_compuerta}, 32'd1);
      cerrar(0, "bq_close");
      tick();
      tick();
      chk("bq_l1_late_con", {30'd0, concesion}, 32'd2);
      solicitud = 2'b00;
      tick();

      // Reset in ABIERTO closes the gate and clears alarms at that edge.
      do_reset("rst3");
      clave_1 = 16'h0001;
      for (int i = 0; i < 3; i++) pedir(2'b10, 2'b10, "ra_w");
      chk("ra_apin", {30'd0, senal_alarma_pin}, 32'd2);
      clave_0 = 16'h3257;
      pedir(2'b01, 2'b01, "ra_open");
      chk("ra_gate", {30'd0, senal_compuerta}, 32'd1);
      do_reset("ra_rst");

      // Gate-open timeout (only when the feature is built in).
      clave_0 = 16'h3257;
      pedir(2'b01, 2'b01, "to_open");
      begin
         int n;
         n = 0;
         while (senal_compuerta[0] && n < 300) begin
            n++;
            tick();
         end
`ifdef TIMEOUT_APERTURA_EN
         chk("to_cycles", n, 32'd200);
`else
         chk("to_cycles", n, 32'd300);
         cerrar(0, "to_close");
`endif
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/arbitro_compuerta.md
ARBITRO_COMPUERTA -- requirements
Module: arbitro_compuerta

Interface
REQ-001 SHALL have parameter CLAVE_CORRECTA, default 16'h3257; the valid 4-digit BCD PIN.
REQ-002 SHALL have parameter MAX_INTENTOS, default 3; number of wrong PINs per lane that raises the PIN alarm.
REQ-003 SHALL have parameter TIEMPO_MAX, default 200; gate-open timeout in clock cycles.
REQ-004 SHALL have port clock, input, 1; the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1; synchronous, active-low reset.
REQ-006 SHALL have port solicitud, input, 2; per-lane PIN-verification request, held until granted.
REQ-007 SHALL have ports clave_0 and clave_1, input, 16 each; PIN presented by lane 0 and lane 1.
REQ-008 SHALL have port sensor_llegada_vehiculo, input, 2; per-lane vehicle-arrival sensor.
REQ-009 SHALL have port sensor_ingreso_vehiculo, input, 2; per-lane vehicle-entry sensor.
REQ-010 SHALL have port concesion, output, 2; one-hot, one-cycle grant of the shared verifier.
REQ-011 SHALL have port senal_compuerta, output, 2; per-lane gate-open command.
REQ-012 SHALL have ports senal_alarma_pin and senal_alarma_bloqueo, output, 2 each; per-lane alarms.

Function
REQ-013 SHALL implement states REPOSO, VERIFICAR, ABIERTO and BLOQUEO; one lane served at a time.
REQ-014 In REPOSO with any solicitud bit high, SHALL select a lane, latch it, and enter VERIFICAR.
REQ-015 Selection SHALL be round-robin: on a simultaneous request, pick the lane not last granted; after reset lane 0 wins.
REQ-016 In VERIFICAR, SHALL drive concesion for the latched lane for exactly one cycle and compare that lane's clave against CLAVE_CORRECTA in the same cycle.
REQ-017 Latency: solicitud sampled at edge k -> concesion high in cycle k+1 -> senal_compuerta high from edge k+2 on a match.
REQ-018 Match: clear that lane's attempt counter and senal_alarma_pin, then go to ABIERTO with senal_compuerta[lane]=1.
REQ-019 Mismatch: saturating-increment that lane's attempt counter (2 bits minimum, saturating at MAX_INTENTOS), then return to REPOSO.
REQ-020 senal_alarma_pin[lane] SHALL set when the counter reaches MAX_INTENTOS and stay set until a correct PIN on that lane or reset.
REQ-021 A solicitud still high in REPOSO after its grant SHALL be treated as a new attempt; requesters deassert after concesion.
REQ-022 In ABIERTO, the gate SHALL close (return to REPOSO) the cycle after sensor_ingreso_vehiculo[lane] falls from 1 to 0.
REQ-023 In ABIERTO, if sensor_llegada_vehiculo[lane] and sensor_ingreso_vehiculo[lane] are both 1 in the same cycle, SHALL close the gate, set senal_alarma_bloqueo[lane], and enter BLOQUEO.
REQ-024 In BLOQUEO, SHALL grant only the blocked lane; a wrong PIN keeps BLOQUEO with no counter change.
REQ-025 In BLOQUEO, a correct PIN SHALL clear senal_alarma_bloqueo[lane] and enter ABIERTO for that lane.
REQ-026 Requests from the non-served lane SHALL be held off (no concesion) and never lost while their solicitud stays high.
REQ-027 senal_compuerta SHALL be one-hot or zero at all times; concesion likewise.

Reset
REQ-028 With reset=0 at a rising edge, SHALL enter REPOSO and drive all outputs to 0.
REQ-029 Reset SHALL clear the attempt counters, the timeout counter and the round-robin pointer (lane 0 favoured).
REQ-030 Reset asserted in ABIERTO or BLOQUEO SHALL close the gate and clear alarms at that same edge.

Configuration
REQ-031 With macro TIMEOUT_APERTURA_EN defined, SHALL count cycles in ABIERTO and close the gate (to REPOSO) after TIEMPO_MAX cycles if sensor_ingreso_vehiculo[lane] never rose; counter restarts on each ABIERTO entry.
REQ-032 Without TIMEOUT_APERTURA_EN, ABIERTO SHALL persist until the REQ-022/REQ-023 exits, and no timeout counter SHALL be synthesized.

Verification
REQ-033 Lane 0 solicitud with clave_0=16'h3257 -> concesion=2'b01 one cycle later; senal_compuerta=2'b01 at the next edge; ingreso 1->0 -> gate 0 the following cycle.
REQ-034 Lane 1 sends 16'h7523, then 16'h4368, then 16'h2656 -> no gate opening; senal_alarma_pin[1]=1 after the third attempt; then 16'h3257 -> alarm cleared, gate opens.
REQ-035 Both lanes request at once after reset -> lane 0 granted first, lane 1 granted after lane 0's gate closes; the next simultaneous request grants lane 1 first.
REQ-036 Lane 0 open with llegada=1 and ingreso=1 in the same cycle -> senal_alarma_bloqueo[0]=1, gate closed; 16'h5479 -> stays blocked; 16'h3257 -> alarm cleared, gate reopens.
REQ-037 With TIMEOUT_APERTURA_EN, open lane 0 with no ingreso -> gate drops after exactly 200 cycles; reset pulse mid-ABIERTO -> all outputs 0 at that edge.
